div_by_x_plus_1: RTL and testbench

//  Exact division of a GF(2) polynomial by (x+1), computed W coefficients per cycle.

---
 rtl/div_by_x_plus_1.sv | 115 +++++++++++
 tb/tb_div_by_x_plus_1.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_by_x_plus_1.sv
// Exact GF(2) division by (x+1): running prefix XOR over N coefficients,
// W coefficients per cycle, with a flag for inputs of odd weight.
module div_by_x_plus_1 #(
  parameter int unsigned N = 1120,
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] p,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         not_exact
);

  localparam int unsigned NC = N / W;
  localparam int unsigned CW = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(NC - 1);

  // A partial last chunk is not supported; stop elaboration.
  generate
    if ((N % W) != 0) begin : g_bad_width
      $error("div_by_x_plus_1: N must be a multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  p_hold, p_hold_nxt;
  logic [N-1:0]  q_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          carry, carry_nxt;
  logic          busy_nxt, done_nxt, not_exact_nxt;
  logic [IW-1:0] base;
  logic [W-1:0]  chunk_p, chunk_q;
  logic          t;

  // Prefix XOR of the current chunk, seeded with the carry from the chunk below.
  always_comb begin
    base    = IW'(cnt) * IW'(W);
    chunk_p = p_hold[base +: W];
    chunk_q = '0;
    t       = carry;
    for (int j = 0; j < int'(W); j++) begin
      chunk_q[j] = chunk_p[j] ^ t;
      t          = chunk_q[j];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p_hold    <= '0;
      q         <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      not_exact <= 1'b0;
    end else begin
      state     <= state_nxt;
      p_hold    <= p_hold_nxt;
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      carry     <= carry_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      not_exact <= not_exact_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    p_hold_nxt    = p_hold;
    q_nxt         = q;
    cnt_nxt       = cnt;
    carry_nxt     = carry;
    busy_nxt      = busy;
    done_nxt      = done;
    not_exact_nxt = not_exact;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          p_hold_nxt    = p;
          q_nxt         = '0;
          cnt_nxt       = '0;
          carry_nxt     = 1'b0;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          not_exact_nxt = 1'b0;
          state_nxt     = RUN;
        end
      end
      RUN: begin
        q_nxt[base +: W] = chunk_q;
        carry_nxt        = chunk_q[W-1];
        if (cnt == LAST) begin
          busy_nxt      = 1'b0;
          done_nxt      = 1'b1;
          not_exact_nxt = chunk_q[W-1];
          state_nxt     = DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_by_x_plus_1.sv
// Randomized self-checking bench for div_by_x_plus_1 against a polynomial model.
module tb_div_by_x_plus_1;

  localparam int unsigned N   = 1120;
  localparam int unsigned W   = 32;
  localparam int          LAT = N / W;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] p;
  logic [N-1:0] q;
  logic         busy, done, not_exact;

  int checks = 0;
  int errors = 0;

  div_by_x_plus_1 #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .p(p), .q(q),
    .busy(busy), .done(done), .not_exact(not_exact)
  );

  always #5 clk = ~clk;

  // Quotient model: q(x) = p(x)/(x+1) over GF(2), i.e. running parity from x^0 up.
  function automatic logic [N-1:0] model_q(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      acc  = acc ^ v[i];
      r[i] = acc;
    end
    return r;
  endfunction

  // (x+1)*r over GF(2).
  function automatic logic [N-1:0] mul_x1(input logic [N-1:0] r);
    return r ^ (r << 1);
  endfunction

  function automatic logic [N-1:0] rand_poly();
    logic [N-1:0] v;
    for (int i = 0; i < int'(N / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Start an operation and count cycles until done (bounded).
  task automatic run_op(input logic [N-1:0] pv, output int lat);
    @(posedge clk); #1;
    p = pv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; p = '0;
    #12;
    checks++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL reset: q_lo=%0h busy=%b done=%b ne=%b, want all 0", q[63:0], busy, done, not_exact);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [N-1:0] pv;
    pv = N'(3);
    @(posedge clk); #1;
    p = pv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_busy: busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    while (!done && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== LAT || busy !== 1'b0) begin
      errors++;
      $display("FAIL latency_x1: lat=%0d busy=%b, want %0d 0", lat, busy, LAT);
    end
    checks++;
    if (q !== N'(1) || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL x_plus_1: q_lo=%0h ne=%b, want 1 0", q[63:0], not_exact);
    end
    // x^4+x^2 -> x^3+x^2, which is again divisible by (x+1) for the next stage.
    run_op(N'(5'b10100), lat);
    checks++;
    if (q !== N'(5'b01100) || not_exact !== 1'b0 || lat !== LAT) begin
      errors++;
      $display("FAIL x4_x2: q_lo=%0h ne=%b lat=%0d, want c 0 %0d", q[63:0], not_exact, lat, LAT);
    end
    checks++;
    if (^q !== 1'b0) begin
      errors++;
      $display("FAIL chain_parity: got %b want 0", ^q);
    end
  endtask

  task automatic test_chunk_carry();
    int lat;
    logic [N-1:0] pv, want;
    pv = '0; pv[32] = 1'b1; pv[31] = 1'b1;
    want = '0; want[31] = 1'b1;
    run_op(pv, lat);
    checks++;
    if (q !== want || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL carry_32: q_lo=%0h ne=%b, want %0h 0", q[63:0], not_exact, want[63:0]);
    end
    pv = '0; pv[N-1] = 1'b1; pv[N-2] = 1'b1;
    want = '0; want[N-2] = 1'b1;
    run_op(pv, lat);
    checks++;
    if (q !== want || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL carry_top: q_hi=%0h ne=%b, want %0h 0", q[N-1 -: 64], not_exact, want[N-1 -: 64]);
    end
  endtask

  task automatic test_non_exact();
    int lat;
    run_op(N'(1), lat);
    checks++;
    if (q !== '1 || not_exact !== 1'b1) begin
      errors++;
      $display("FAIL p_one: q_hi=%0h ne=%b, want all ones 1", q[N-1 -: 64], not_exact);
    end
    run_op('0, lat);
    checks++;
    if (q !== '0 || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL p_zero: q_lo=%0h ne=%b, want 0 0", q[63:0], not_exact);
    end
    for (int n = 0; n < 40; n++) begin
      logic [N-1:0] pv, want;
      pv = rand_poly();
      want = model_q(pv);
      run_op(pv, lat);
      checks++;
      if (q !== want || not_exact !== ^pv) begin
        errors++;
        $display("FAIL rand_any[%0d]: q_lo=%0h ne=%b, want %0h %b", n, q[63:0], not_exact, want[63:0], ^pv);
      end
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    @(posedge clk); #1;
    p = N'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (q !== '0 || busy !== 1'b0 || done !== 1'b0 || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: q_lo=%0h busy=%b done=%b, want 0 0 0", q[63:0], busy, done);
    end
    @(negedge clk); rst = 1'b0;
    run_op(N'(3), lat);
    checks++;
    if (q !== N'(1) || lat !== LAT || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: q_lo=%0h lat=%0d, want 1 %0d", q[63:0], lat, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [N-1:0] r, pv;
    // start and p changes during RUN must have no effect
    @(posedge clk); #1;
    p = N'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 4 * LAT) begin
      if (lat == 5) begin start = 1'b1; p = N'(1); end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== LAT || q !== N'(1) || not_exact !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: lat=%0d q_lo=%0h ne=%b, want %0d 1 0", lat, q[63:0], not_exact, LAT);
    end
    // restart directly from DONE
    p = N'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: done=%b busy=%b, want 0 1", done, busy);
    end
    lat = 0;
    while (!done && lat < 4 * LAT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== LAT || q !== '1 || not_exact !== 1'b1) begin
      errors++;
      $display("FAIL restart_result: lat=%0d ne=%b, want %0d 1", lat, not_exact, LAT);
    end
    // exact multiples of (x+1) divide back to the cofactor
    for (int n = 0; n < 500; n++) begin
      r = rand_poly();
      r[N-1] = 1'b0;
      pv = mul_x1(r);
      run_op(pv, lat);
      checks++;
      if (q !== r || not_exact !== 1'b0 || lat !== LAT) begin
        errors++;
        $display("FAIL rand_exact[%0d]: q_lo=%0h ne=%b lat=%0d, want %0h 0 %0d", n, q[63:0], not_exact, lat, r[63:0], LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chunk_carry();
    test_non_exact();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
